// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans an N_ROWS x N_COLS matrix keypad. One column is driven low at a
//   time. The synchronized rows are sampled on the last dwell cycle of each
//   column. A detected key is debounced on press and again on release.
//   Each accepted key is reported exactly once.
// Ports:
//   clk_i        system clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   row_i        raw keypad rows, active-low, asynchronous to clk_i
//   col_o        column drive, active-low, exactly one bit low
//   key_code_o   last accepted key, row*N_COLS + col
//   key_valid_o  one-cycle pulse on acceptance
//   key_held_o   high from acceptance until debounced release
module keypad_scanner #(
   parameter int N_ROWS          = 4,
   parameter int N_COLS          = 4,
   parameter int SCAN_CYCLES     = 1000,
   parameter int DEBOUNCE_CYCLES = 100000,
   localparam int CODE_W         = $clog2(N_ROWS*N_COLS)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [N_ROWS-1:0] row_i,
   output logic [N_COLS-1:0] col_o,
   output logic [CODE_W-1:0] key_code_o,
   output logic              key_valid_o,
   output logic              key_held_o
);

   localparam int RW      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int CW      = $clog2(N_COLS);
   localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]     COL_LAST  = CW'(N_COLS - 1);
   localparam logic [N_COLS-1:0] COL_ONE   = N_COLS'(1);

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_e;

   state_e              state_q;
   logic [N_ROWS-1:0]   sync1_q, sync2_q;
   logic [CW-1:0]       col_idx_q;
   logic [N_COLS-1:0]   col_q;
   logic [RW-1:0]       row_idx_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CODE_W-1:0]   code_q;
   logic                valid_q;
   logic                held_q;

   logic                key_any;
   logic [RW-1:0]       low_idx_d;
   logic                row_low;
   logic [CW-1:0]       col_idx_d;
   logic [N_COLS-1:0]   col_d;
   logic [CODE_W-1:0]   code_d;

   assign key_any = ~&sync2_q;
   assign row_low = ~sync2_q[row_idx_q];

   // Walk from the top row down so the lowest-index low row wins.
   always_comb begin
      low_idx_d = '0;
      for (int i = N_ROWS - 1; i >= 0; i--) begin
         if (!sync2_q[i]) low_idx_d = RW'(i);
      end
   end

   assign col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
   assign col_d     = ~(COL_ONE << col_idx_d);
   assign code_d    = CODE_W'(int'(row_idx_q) * N_COLS + int'(col_idx_q));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_SCAN;
         sync1_q   <= '1;
         sync2_q   <= '1;
         col_idx_q <= '0;
         col_q     <= ~COL_ONE;
         row_idx_q <= '0;
         cnt_q     <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         sync1_q <= row_i;
         sync2_q <= sync1_q;
         valid_q <= 1'b0;
         case (state_q)
            S_SCAN: begin
               if (cnt_q == SCAN_LAST) begin
                  cnt_q <= '0;
                  if (key_any) begin
                     // Column stays where it is while the key is qualified.
                     row_idx_q <= low_idx_d;
                     state_q   <= S_DEBOUNCE;
                  end else begin
                     col_idx_q <= col_idx_d;
                     col_q     <= col_d;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DEBOUNCE: begin
               if (!row_low) begin
                  cnt_q   <= '0;
                  state_q <= S_SCAN;
               end else if (cnt_q == DEB_LAST) begin
                  cnt_q   <= '0;
                  code_q  <= code_d;
                  valid_q <= 1'b1;
                  held_q  <= 1'b1;
                  state_q <= S_HELD;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_HELD: begin
               if (!row_low) begin
                  cnt_q   <= '0;
                  state_q <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (row_low) begin
                  cnt_q   <= '0;
                  state_q <= S_HELD;
               end else if (cnt_q == DEB_LAST) begin
                  cnt_q   <= '0;
                  held_q  <= 1'b0;
                  state_q <= S_SCAN;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= S_SCAN;
            end
         endcase
      end
   end

   assign col_o       = col_q;
   assign key_code_o  = code_q;
   assign key_valid_o = valid_q;
   assign key_held_o  = held_q;

endmodule
